cla_seq_adder_ctrl: RTL and testbench

Sequencing and arbitration controller for the team's 4-bit carry-lookahead adder slice. It accepts WIDTH-bit add requests from two independent requesters and arbitrates between them round-robin. It runs each accepted operation through one 4-bit CLA slice, one nibble per cycle, with a registered inter-nibble carry, and returns the full-width sum and carry-out on a valid/ready result port. It sits between the requesters and the shared adder datapath so that wide additions reuse a single 4-bit CLA.

---
 rtl/cla_seq_adder_ctrl_if.sv | 37 +++
 rtl/cla_seq_adder_ctrl.sv | 128 ++++++++++++
 tb/tb_cla_seq_adder_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cla_seq_adder_ctrl_if.sv
// Request/result bundle for the sequential CLA adder controller.
// Master drives requests and result back-pressure; slave is the controller.
interface cla_seq_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_id;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_sum, res_cout, res_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_sum, res_cout, res_id
    );
endinterface

// File: rtl/cla_seq_adder_ctrl.sv
// Round-robin front end that runs WIDTH-bit adds through one 4-bit CLA,
// one nibble per cycle with a registered inter-nibble carry.
module cla_seq_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cla_seq_adder_ctrl_if.slave  bus
);
    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic             last;
    logic [KW-1:0]    k;
    logic             carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             id;
    logic             valid;

    logic             g0;
    logic             g1;
    logic             rdy0;
    logic             rdy1;
    logic             acc;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [4:0]       slice;

    // 4-bit carry-lookahead slice: {cout, sum}
    function automatic logic [4:0] cla4(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       c0
    );
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = a ^ b;
        g    = a & b;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Round-robin grant: on a tie the requester not served last wins
    always_comb begin
        g0 = bus.req0_valid & (~bus.req1_valid | last);
        g1 = bus.req1_valid & (~bus.req0_valid | ~last);
    end

    assign rdy0 = (state == IDLE) & g0 & ~rst;
    assign rdy1 = (state == IDLE) & g1 & ~rst;
    assign acc  = rdy0 | rdy1;

    // Current nibble through the shared CLA slice
    always_comb begin
        nib_a = op_a[{k, 2'b00} +: 4];
        nib_b = op_b[{k, 2'b00} +: 4];
        slice = cla4(nib_a, nib_b, carry);
    end

    // Control FSM with registered result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
            k     <= '0;
            carry <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            id    <= 1'b0;
            valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (acc) begin
                        op_a  <= rdy1 ? bus.req1_a : bus.req0_a;
                        op_b  <= rdy1 ? bus.req1_b : bus.req0_b;
                        carry <= rdy1 ? bus.req1_cin : bus.req0_cin;
                        id    <= rdy1;
                        last  <= rdy1;
                        k     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[{k, 2'b00} +: 4] <= slice[3:0];
                    carry <= slice[4];
                    k     <= k + 1'b1;
                    if (k == KLAST) begin
                        cout  <= slice[4];
                        valid <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.res_valid  = valid;
    assign bus.res_sum    = sum;
    assign bus.res_cout   = cout;
    assign bus.res_id     = id;
endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Directed bench for cla_seq_adder_ctrl at WIDTH=16.
// Checks latency, carries, arbitration, back-pressure and reset abort.
module tb_cla_seq_adder_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    cla_seq_adder_ctrl_if #(.WIDTH(16)) bus ();

    cla_seq_adder_ctrl #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation with fixed-latency checks
    task automatic do_op(input string tag, input bit rid,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] es,
                         input logic ec, input bit scramble);
        @(negedge clk);
        if (rid) begin
            bus.req1_a = a; bus.req1_b = b;
            bus.req1_cin = cin; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_a = a; bus.req0_b = b;
            bus.req0_cin = cin; bus.req0_valid = 1'b1;
        end
        #1;
        check({tag, "_rdy"},
              rid ? bus.req1_ready : bus.req0_ready, 1);
        check({tag, "_rdy_other"},
              rid ? bus.req0_ready : bus.req1_ready, 0);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        if (scramble) begin
            bus.req0_a = ~a; bus.req0_b = ~b; bus.req0_cin = ~cin;
            bus.req1_a = ~a; bus.req1_b = ~b; bus.req1_cin = ~cin;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({tag, "_early"}, bus.res_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, bus.res_valid, 1);
        check({tag, "_sum"}, bus.res_sum, es);
        check({tag, "_cout"}, bus.res_cout, ec);
        check({tag, "_id"}, bus.res_id, rid);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        check({tag, "_drop"}, bus.res_valid, 0);
    endtask

    initial begin
        int nres;
        int nacc;
        int last_acc;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0;
        bus.req0_b = '0; bus.req0_cin = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = '0;
        bus.req1_b = '0; bus.req1_cin = 1'b0;
        bus.res_ready = 1'b0;

        // Reset values, and no handshake while rst is high
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        check("rst_valid", bus.res_valid, 0);
        check("rst_sum", bus.res_sum, 0);
        check("rst_cout", bus.res_cout, 0);
        check("rst_id", bus.res_id, 0);
        check("rst_rdy0", bus.req0_ready, 0);
        check("rst_rdy1", bus.req1_ready, 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        do_op("basic", 1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        do_op("ripple_cin", 1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        do_op("ripple_b", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Back-pressure: result held 5 cycles, req0 must not be accepted
        @(negedge clk);
        bus.req1_a = 16'h00AA; bus.req1_b = 16'h0055;
        bus.req1_cin = 1'b0; bus.req1_valid = 1'b1;
        #1;
        check("bp_rdy1", bus.req1_ready, 1);
        @(posedge clk);
        #1;
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1;
        repeat (4) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", bus.res_valid, 1);
            check("bp_sum", bus.res_sum, 16'h00FF);
            check("bp_id", bus.res_id, 1);
            check("bp_rdy0", bus.req0_ready, 0);
            check("bp_rdy1", bus.req1_ready, 0);
        end
        bus.req0_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        check("bp_done", bus.res_valid, 0);

        // Reset in RUN at nibble 2 abandons the operation
        @(negedge clk);
        bus.req1_a = 16'hFFFF; bus.req1_b = 16'h0001;
        bus.req1_cin = 1'b0; bus.req1_valid = 1'b1;
        #1;
        check("abort_rdy1", bus.req1_ready, 1);
        @(posedge clk);
        #1;
        bus.req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.req0_valid = 1'b1;
        rst = 1'b1;
        #1;
        check("abort_valid", bus.res_valid, 0);
        check("abort_sum", bus.res_sum, 0);
        check("abort_cout", bus.res_cout, 0);
        check("abort_id", bus.res_id, 0);
        check("abort_rdy0", bus.req0_ready, 0);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_stale", bus.res_valid, 0);
        end
        do_op("post_rst", 1'b0, 16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0);

        // Operands changed after accept must not matter
        do_op("capture", 1'b0, 16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0, 1'b1);

        // Arbitration from fresh reset: both valid, strict alternation
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req0_a = 16'h0001; bus.req0_b = 16'h0001; bus.req0_cin = 1'b0;
        bus.req1_a = 16'h8000; bus.req1_b = 16'h8000; bus.req1_cin = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.res_ready = 1'b1;
        nres = 0;
        nacc = 0;
        last_acc = -1;
        for (int cyc = 0; cyc < 60 && nres < 4; cyc++) begin
            #1;
            if (bus.req0_ready | bus.req1_ready) begin
                check("arb_grant", bus.req1_ready, nacc % 2);
                if (last_acc >= 0)
                    check("arb_space", cyc - last_acc, 6);
                last_acc = cyc;
                nacc++;
            end
            if (bus.res_valid) begin
                check("arb_id", bus.res_id, nres % 2);
                check("arb_sum", bus.res_sum,
                      (nres % 2) ? 16'h0000 : 16'h0002);
                check("arb_cout", bus.res_cout, nres % 2);
                nres++;
                if (nres == 4) begin
                    bus.req0_valid = 1'b0;
                    bus.req1_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        check("arb_count", nres, 4);
        bus.res_ready = 1'b0;
        #1;
        check("arb_idle_valid", bus.res_valid, 0);
        check("arb_idle_rdy", {bus.req0_ready, bus.req1_ready}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
